// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file: defaults, address/data types
// and the address-validity rule used by the data array and the scoreboard.
package regfile_pkg;

    localparam int DEF_XLEN  = 32;
    localparam int DEF_NREGS = 32;
    localparam int DEF_AW    = $clog2(DEF_NREGS);

    typedef logic [DEF_AW-1:0]   reg_addr_t;
    typedef logic [DEF_XLEN-1:0] xlen_t;

    // An address is live if it names an implemented register other than a hardwired x0.
    function automatic logic addr_valid(input logic [31:0] addr, input int nregs, input int zero_reg);
        return (addr < 32'(nregs)) && !((zero_reg != 0) && (addr == 32'd0));
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits: set by issue, cleared by writeback (issue wins on a tie),
// plus the per-read-port busy lookup.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREGS    = DEF_NREGS,
    parameter int NRD      = 2,
    parameter int NWR      = 2,
    parameter int ZERO_REG = 1,
    parameter int AW       = $clog2(NREGS)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    issue_en,
    input  logic [AW-1:0]           issue_addr,
    input  logic [NWR-1:0]          wr_valid,
    input  logic [NWR-1:0][AW-1:0]  wr_addr,
    input  logic [NRD-1:0][AW-1:0]  rd_addr,
    input  logic [NRD-1:0]          rd_fwd,
    output logic [NRD-1:0]          rd_busy
);

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;
    logic             issue_valid;

    assign issue_valid = issue_en && addr_valid(32'(issue_addr), NREGS, ZERO_REG);

    always_comb begin
        busy_d = busy_q;
        for (int i = 0; i < NREGS; i++) begin
            for (int p = 0; p < NWR; p++) begin
                if (wr_valid[p] && (wr_addr[p] == AW'(i))) begin
                    busy_d[i] = 1'b0;
                end
            end
            // A new producer issued in the same cycle outlives the old one's writeback.
            if (issue_valid && (issue_addr == AW'(i))) begin
                busy_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    generate
        for (genvar gi = 0; gi < NRD; gi++) begin : g_rd_busy
            logic busy_sel;
            always_comb begin
                busy_sel = 1'b0;
                for (int i = 0; i < NREGS; i++) begin
                    if (rd_addr[gi] == AW'(i)) begin
                        busy_sel = busy_q[i];
                    end
                end
            end
            assign rd_busy[gi] = addr_valid(32'(rd_addr[gi]), NREGS, ZERO_REG) && !rd_fwd[gi] && busy_sel;
        end
    endgenerate

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with optional hardwired x0, write-to-read bypass,
// busy scoreboard and a registered same-address write-conflict flag.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int XLEN     = DEF_XLEN,
    parameter int NREGS    = DEF_NREGS,
    parameter int NRD      = 2,
    parameter int NWR      = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    localparam int AW      = $clog2(NREGS)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NWR-1:0]           wr_en,
    input  logic [NWR-1:0][AW-1:0]   wr_addr,
    input  logic [NWR-1:0][XLEN-1:0] wr_data,
    input  logic [NRD-1:0][AW-1:0]   rd_addr,
    output logic [NRD-1:0][XLEN-1:0] rd_data,
    output logic [NRD-1:0]           rd_busy,
    input  logic                     issue_en,
    input  logic [AW-1:0]            issue_addr,
    output logic                     wr_conflict
);

    logic [XLEN-1:0] regs_q [NREGS];
    logic [XLEN-1:0] regs_d [NREGS];
    logic [NWR-1:0]  wr_valid;
    logic [NRD-1:0]  rd_fwd;
    logic            wr_conflict_q;
    logic            wr_conflict_d;

    always_comb begin
        for (int p = 0; p < NWR; p++) begin
            wr_valid[p] = wr_en[p] && addr_valid(32'(wr_addr[p]), NREGS, ZERO_REG);
        end
    end

    // Ports are scanned in ascending order so the highest-index writer wins.
    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            regs_d[i] = regs_q[i];
            for (int p = 0; p < NWR; p++) begin
                if (wr_valid[p] && (wr_addr[p] == AW'(i))) begin
                    regs_d[i] = wr_data[p];
                end
            end
        end
    end

    always_comb begin
        wr_conflict_d = 1'b0;
        for (int p = 0; p < NWR; p++) begin
            for (int q = p + 1; q < NWR; q++) begin
                if (wr_valid[p] && wr_valid[q] && (wr_addr[p] == wr_addr[q])) begin
                    wr_conflict_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
            wr_conflict_q <= 1'b0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
            wr_conflict_q <= wr_conflict_d;
        end
    end

    assign wr_conflict = wr_conflict_q;

    generate
        for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
            logic            rd_valid;
            logic            fwd_hit;
            logic [XLEN-1:0] fwd_data;
            logic [XLEN-1:0] stored;

            always_comb begin
                rd_valid = addr_valid(32'(rd_addr[gi]), NREGS, ZERO_REG);
                stored   = '0;
                for (int i = 0; i < NREGS; i++) begin
                    if (rd_addr[gi] == AW'(i)) begin
                        stored = regs_q[i];
                    end
                end
                fwd_hit  = 1'b0;
                fwd_data = '0;
                if (BYPASS != 0) begin
                    for (int p = 0; p < NWR; p++) begin
                        if (wr_valid[p] && (wr_addr[p] == rd_addr[gi])) begin
                            fwd_hit  = 1'b1;
                            fwd_data = wr_data[p];
                        end
                    end
                end
            end

            assign rd_fwd[gi]  = rd_valid && fwd_hit;
            assign rd_data[gi] = !rd_valid ? '0 : (fwd_hit ? fwd_data : stored);
        end
    endgenerate

    regfile_scoreboard #(
        .NREGS    (NREGS),
        .NRD      (NRD),
        .NWR      (NWR),
        .ZERO_REG (ZERO_REG),
        .AW       (AW)
    ) u_scoreboard (
        .clk        (clk),
        .reset      (reset),
        .issue_en   (issue_en),
        .issue_addr (issue_addr),
        .wr_valid   (wr_valid),
        .wr_addr    (wr_addr),
        .rd_addr    (rd_addr),
        .rd_fwd     (rd_fwd),
        .rd_busy    (rd_busy)
    );

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: instance A (32 regs, bypass) and instance B (24 regs, no bypass)
// share stimulus; a directed table plus random cycles are checked against a reference model.
module tb_regfile_mp;

    localparam int XLEN = 32;
    localparam int NRD  = 2;
    localparam int NWR  = 2;
    localparam int AW   = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                      reset;
    logic [NWR-1:0]            wr_en;
    logic [NWR-1:0][AW-1:0]    wr_addr;
    logic [NWR-1:0][XLEN-1:0]  wr_data;
    logic [NRD-1:0][AW-1:0]    rd_addr;
    logic                      issue_en;
    logic [AW-1:0]             issue_addr;
    logic [NRD-1:0][XLEN-1:0]  rd_data_a, rd_data_b;
    logic [NRD-1:0]            rd_busy_a, rd_busy_b;
    logic                      conf_a, conf_b;

    regfile_mp #(.XLEN(XLEN), .NREGS(32), .NRD(NRD), .NWR(NWR), .ZERO_REG(1), .BYPASS(1)) u_a (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(rd_data_a), .rd_busy(rd_busy_a),
        .issue_en(issue_en), .issue_addr(issue_addr), .wr_conflict(conf_a)
    );

    regfile_mp #(.XLEN(XLEN), .NREGS(24), .NRD(NRD), .NWR(NWR), .ZERO_REG(1), .BYPASS(0)) u_b (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
        .issue_en(issue_en), .issue_addr(issue_addr), .wr_conflict(conf_b)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int          nregs_m [2] = '{32, 24};
    bit          byp_m   [2] = '{1'b1, 1'b0};
    logic [31:0] mregs   [2][32];
    bit          mbusy   [2][32];
    bit          mconf   [2];
    bit          model_ok = 1'b0;

    function automatic bit mvalid(input int b, input int a);
        return (a < nregs_m[b]) && (a != 0);
    endfunction

    task automatic model_read(input int b, input int a, output logic [31:0] d, output bit busy);
        bit hit = 1'b0;
        d    = 32'd0;
        busy = 1'b0;
        if (mvalid(b, a)) begin
            d = mregs[b][a];
            if (byp_m[b]) begin
                for (int p = 0; p < NWR; p++) begin
                    if (wr_en[p] && mvalid(b, int'(wr_addr[p])) && int'(wr_addr[p]) == a) begin
                        d   = wr_data[p];
                        hit = 1'b1;
                    end
                end
            end
            busy = mbusy[b][a] && !hit;
        end
    endtask

    task automatic model_update();
        for (int b = 0; b < 2; b++) begin
            if (reset) begin
                for (int i = 0; i < 32; i++) begin
                    mregs[b][i] = 32'd0;
                    mbusy[b][i] = 1'b0;
                end
                mconf[b] = 1'b0;
            end else begin
                int hits [32];
                mconf[b] = 1'b0;
                for (int i = 0; i < 32; i++) hits[i] = 0;
                for (int p = 0; p < NWR; p++) begin
                    if (wr_en[p] && mvalid(b, int'(wr_addr[p]))) begin
                        hits[wr_addr[p]]++;
                        mregs[b][wr_addr[p]] = wr_data[p];
                        mbusy[b][wr_addr[p]] = 1'b0;
                    end
                end
                for (int i = 0; i < 32; i++) if (hits[i] > 1) mconf[b] = 1'b1;
                if (issue_en && mvalid(b, int'(issue_addr))) mbusy[b][issue_addr] = 1'b1;
            end
        end
    endtask

    task automatic check_model();
        logic [31:0] d;
        bit          bz;
        for (int r = 0; r < NRD; r++) begin
            model_read(0, int'(rd_addr[r]), d, bz);
            check($sformatf("cyc%0d A rd%0d x%0d data", cyc, r, rd_addr[r]), rd_data_a[r], d);
            check($sformatf("cyc%0d A rd%0d x%0d busy", cyc, r, rd_addr[r]), 32'(rd_busy_a[r]), 32'(bz));
            model_read(1, int'(rd_addr[r]), d, bz);
            check($sformatf("cyc%0d B rd%0d x%0d data", cyc, r, rd_addr[r]), rd_data_b[r], d);
            check($sformatf("cyc%0d B rd%0d x%0d busy", cyc, r, rd_addr[r]), 32'(rd_busy_b[r]), 32'(bz));
        end
        check($sformatf("cyc%0d A wr_conflict", cyc), 32'(conf_a), 32'(mconf[0]));
        check($sformatf("cyc%0d B wr_conflict", cyc), 32'(conf_b), 32'(mconf[1]));
    endtask

    // Observe outputs mid-cycle, then clock and advance the model.
    task automatic run_cycle();
        #2;
        if (model_ok) check_model();
        @(posedge clk);
        if (model_ok || reset) begin
            model_update();
            model_ok = 1'b1;
        end
        #1;
        cyc++;
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        bit          rst;
        logic [1:0]  we;
        logic [4:0]  wa0;
        logic [31:0] wd0;
        logic [4:0]  wa1;
        logic [31:0] wd1;
        logic [4:0]  ra0;
        bit          ie;
        logic [4:0]  ia;
        bit          chk;
        logic [31:0] exp_da;
        bit          exp_ba;
        logic [31:0] exp_db;
        bit          exp_bb;
        bit          exp_cf;
    } vec_t;

    function automatic vec_t mk(input int rst, input int we, input int wa0, input logic [31:0] wd0,
                                input int wa1, input logic [31:0] wd1, input int ra0, input int ie,
                                input int ia, input int chk, input logic [31:0] da, input int ba,
                                input logic [31:0] db, input int bb, input int cf);
        vec_t v;
        v.rst = bit'(rst);   v.we = 2'(we);     v.wa0 = 5'(wa0); v.wd0 = wd0;
        v.wa1 = 5'(wa1);     v.wd1 = wd1;       v.ra0 = 5'(ra0); v.ie = bit'(ie);
        v.ia = 5'(ia);       v.chk = bit'(chk); v.exp_da = da;   v.exp_ba = bit'(ba);
        v.exp_db = db;       v.exp_bb = bit'(bb); v.exp_cf = bit'(cf);
        return v;
    endfunction

    vec_t vecs [$];

    initial begin
        reset = 1'b1; wr_en = '0; wr_addr = '0; wr_data = '0;
        rd_addr = '0; issue_en = 1'b0; issue_addr = '0;

        //            rst we wa0 wd0           wa1 wd1   ra0 ie ia chk da            ba db            bb cf
        vecs.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0, 0,  0, 0, 0, 32'h0,        0, 32'h0,        0, 0));
        vecs.push_back(mk(0, 1, 5, 32'hDEADBEEF, 0, 32'h0, 5,  0, 0, 1, 32'hDEADBEEF, 0, 32'h0,        0, 0));
        vecs.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0, 5,  0, 0, 1, 32'hDEADBEEF, 0, 32'hDEADBEEF, 0, 0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0, 5,  0, 0, 1, 32'h0,        0, 32'h0,        0, 0));
        vecs.push_back(mk(1, 1, 6, 32'h77,       0, 32'h0, 0,  0, 0, 1, 32'h0,        0, 32'h0,        0, 0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0, 6,  0, 0, 1, 32'h0,        0, 32'h0,        0, 0));
        vecs.push_back(mk(0, 1, 0, 32'h12345678, 0, 32'h0, 0,  1, 0, 1, 32'h0,        0, 32'h0,        0, 0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0, 0,  0, 0, 1, 32'h0,        0, 32'h0,        0, 0));
        vecs.push_back(mk(0, 1, 7, 32'hA5A5A5A5, 0, 32'h0, 7,  0, 0, 1, 32'hA5A5A5A5, 0, 32'h0,        0, 0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0, 7,  0, 0, 1, 32'hA5A5A5A5, 0, 32'hA5A5A5A5, 0, 0));
        vecs.push_back(mk(0, 3, 3, 32'h11,       3, 32'h22, 3, 0, 0, 1, 32'h22,       0, 32'h0,        0, 0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0, 3,  0, 0, 1, 32'h22,       0, 32'h22,       0, 1));
        vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0, 3,  0, 0, 1, 32'h22,       0, 32'h22,       0, 0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0, 9,  1, 9, 1, 32'h0,        0, 32'h0,        0, 0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0, 9,  0, 0, 1, 32'h0,        1, 32'h0,        1, 0));
        vecs.push_back(mk(0, 1, 9, 32'h99,       0, 32'h0, 9,  1, 9, 1, 32'h99,       0, 32'h0,        1, 0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0, 9,  0, 0, 1, 32'h99,       1, 32'h99,       1, 0));
        vecs.push_back(mk(0, 2, 0, 32'h0,        9, 32'h9A, 9, 0, 0, 1, 32'h9A,       0, 32'h99,       1, 0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0, 9,  0, 0, 1, 32'h9A,       0, 32'h9A,       0, 0));
        vecs.push_back(mk(0, 1, 28, 32'hCAFE,    0, 32'h0, 28, 1, 28, 1, 32'hCAFE,    0, 32'h0,        0, 0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0, 28, 0, 0, 1, 32'hCAFE,     1, 32'h0,        0, 0));

        foreach (vecs[i]) begin
            reset      = vecs[i].rst;
            wr_en      = vecs[i].we;
            wr_addr[0] = vecs[i].wa0;
            wr_data[0] = vecs[i].wd0;
            wr_addr[1] = vecs[i].wa1;
            wr_data[1] = vecs[i].wd1;
            rd_addr[0] = vecs[i].ra0;
            rd_addr[1] = vecs[i].ra0 + 5'd1;
            issue_en   = vecs[i].ie;
            issue_addr = vecs[i].ia;
            if (vecs[i].chk) begin
                #1;
                check($sformatf("vec%0d A data", i), rd_data_a[0], vecs[i].exp_da);
                check($sformatf("vec%0d A busy", i), 32'(rd_busy_a[0]), 32'(vecs[i].exp_ba));
                check($sformatf("vec%0d B data", i), rd_data_b[0], vecs[i].exp_db);
                check($sformatf("vec%0d B busy", i), 32'(rd_busy_b[0]), 32'(vecs[i].exp_bb));
                check($sformatf("vec%0d conflict", i), 32'(conf_a), 32'(vecs[i].exp_cf));
                #1;
            end else begin
                #2;
            end
            #(-0) ;
            @(posedge clk);
            if (model_ok || reset) begin
                model_update();
                model_ok = 1'b1;
            end
            #1;
            cyc++;
        end

        // Random traffic, addresses biased toward a small window to provoke collisions.
        for (int n = 0; n < 1500; n++) begin
            reset    = ($urandom_range(0, 63) == 0);
            wr_en    = 2'($urandom_range(0, 3));
            issue_en = ($urandom_range(0, 2) == 0);
            for (int p = 0; p < NWR; p++) begin
                wr_addr[p] = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
                wr_data[p] = $urandom;
            end
            for (int r = 0; r < NRD; r++) begin
                rd_addr[r] = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
            end
            issue_addr = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
            run_cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
